// File: rtl/instr_mem_if.sv
// Bus between the IF-stage controller (master) and the instruction memory (slave).
// INSTR_MEM_PARITY_EN adds the parity_err response signal.
interface instr_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  load_start;
    logic                  load_we;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  stall;
    logic                  flush;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  instr_valid;
    logic                  fault;
    logic                  busy;
    logic [CNT_W-1:0]      load_count;
    logic                  load_overflow;
`ifdef INSTR_MEM_PARITY_EN
    logic                  parity_err;
`endif

    // Handshake: fetch_req/pc are sampled on a rising edge while in RUN and not stalled or
    // flushed; the response (instruction, fault) is qualified by instr_valid one edge later.
    // stall holds the response, flush clears it; there is no other backpressure.
    modport master (
        output load_start, load_we, load_data, load_last, fetch_req, pc, stall, flush,
        input  instruction, instr_valid, fault, busy, load_count, load_overflow
`ifdef INSTR_MEM_PARITY_EN
        , input parity_err
`endif
    );

    modport slave (
        input  load_start, load_we, load_data, load_last, fetch_req, pc, stall, flush,
        output instruction, instr_valid, fault, busy, load_count, load_overflow
`ifdef INSTR_MEM_PARITY_EN
        , output parity_err
`endif
    );
endinterface

// File: rtl/instr_mem_banked_loader.sv
// Synchronous-read instruction memory with a runtime program-load port and IF-stage fetch.
// Define INSTR_MEM_PARITY_EN to store a per-word even-parity bit and report parity faults.
module instr_mem_banked_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 32,
    parameter int BASE_ADDR  = 0
) (
    input  logic        clk,
    input  logic        rst,
    instr_mem_if.slave  bus,
    output logic        state_dbg
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
`ifdef INSTR_MEM_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif
    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic {ST_RUN = 1'b0, ST_LOAD = 1'b1} state_t;

    state_t                state, state_nxt;
    logic [MEM_W-1:0]      mem [DEPTH];
    logic [IDX_W-1:0]      wr_ptr;
    logic [MEM_W-1:0]      wr_word;
    logic [MEM_W-1:0]      rd_word;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-3:0] word_off;
    logic [IDX_W-1:0]      rd_idx;
    logic                  addr_bad;
    logic                  load_wr;
    logic                  fetch_en;

    // BASE_ADDR is word aligned, so the low offset bits equal pc[1:0].
    assign offset   = bus.pc - BASE_A;
    assign word_off = offset[ADDR_WIDTH-1:2];
    assign rd_idx   = word_off[IDX_W-1:0];
    assign addr_bad = (offset[1:0] != 2'b00) || (bus.pc < BASE_A) ||
                      (word_off >= (ADDR_WIDTH-2)'(DEPTH));
    assign rd_word  = mem[rd_idx];

`ifdef INSTR_MEM_PARITY_EN
    assign wr_word  = {^bus.load_data, bus.load_data};
`else
    assign wr_word  = bus.load_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN:  if (bus.load_start) state_nxt = ST_LOAD;
            ST_LOAD: if (!bus.load_start && bus.load_we && bus.load_last) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    // load_start wins over a same-cycle write and blocks any fetch on that edge.
    always_comb begin
        bus.busy  = (state == ST_LOAD);
        state_dbg = (state == ST_LOAD);
        load_wr   = (state == ST_LOAD) && bus.load_we && !bus.load_start;
        fetch_en  = (state == ST_RUN) && bus.fetch_req && !bus.load_start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr            <= '0;
            bus.load_count    <= '0;
            bus.load_overflow <= 1'b0;
        end else if (bus.load_start) begin
            wr_ptr            <= '0;
            bus.load_count    <= '0;
            bus.load_overflow <= 1'b0;
        end else if (load_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == IDX_W'(DEPTH - 1)) bus.load_overflow <= 1'b1;
            if (bus.load_count != CNT_W'(DEPTH)) bus.load_count <= bus.load_count + 1'b1;
        end
    end

    // Program storage is deliberately not reset so a reset keeps the loaded image.
    always_ff @(posedge clk) begin
        if (load_wr) mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.instruction <= '0;
            bus.instr_valid <= 1'b0;
            bus.fault       <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
            bus.parity_err  <= 1'b0;
`endif
        end else if (bus.flush) begin
            bus.instruction <= '0;
            bus.instr_valid <= 1'b0;
            bus.fault       <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
            bus.parity_err  <= 1'b0;
`endif
        end else if (bus.stall) begin
            // hold the current response
        end else if (fetch_en) begin
            bus.instr_valid <= 1'b1;
            if (addr_bad) begin
                bus.instruction <= '0;
                bus.fault       <= 1'b1;
`ifdef INSTR_MEM_PARITY_EN
                bus.parity_err  <= 1'b0;
            end else if (^rd_word) begin
                bus.instruction <= '0;
                bus.fault       <= 1'b1;
                bus.parity_err  <= 1'b1;
`endif
            end else begin
                bus.instruction <= rd_word[DATA_WIDTH-1:0];
                bus.fault       <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
                bus.parity_err  <= 1'b0;
`endif
            end
        end else begin
            bus.instruction <= '0;
            bus.instr_valid <= 1'b0;
            bus.fault       <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
            bus.parity_err  <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_instr_mem_banked_loader.sv
// Bench for instr_mem_banked_loader: directed test-plan steps plus randomized fetch traffic
// checked against a word-level reference model of the load and fetch rules.
module tb_instr_mem_banked_loader;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  logic state_dbg, state_dbg_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  instr_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();
  instr_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(4))     bus_b ();

  instr_mem_banked_loader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .BASE_ADDR(0))
    dut (.clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg));

  instr_mem_banked_loader #(.DATA_WIDTH(DW), .DEPTH(4), .ADDR_WIDTH(AW), .BASE_ADDR('h100))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b), .state_dbg(state_dbg_b));

  // clock
  always #5 clk = ~clk;

  // reference model state
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  bit            m_load;
  int            m_ptr;
  int            m_cnt;
  bit            m_ovf;
  bit            e_valid;
  bit            e_fault;
  bit            e_known;
  logic [DW-1:0] exp_q [$];

  logic [DW-1:0] prog [3];
  logic [DW-1:0] last_w;
  logic [DW-1:0] wa, wb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    bus.load_start = 0; bus.load_we = 0; bus.load_data = '0; bus.load_last = 0;
    bus.fetch_req  = 0; bus.pc = '0; bus.stall = 0; bus.flush = 0;
  endtask

  task automatic set_idle_b();
    bus_b.load_start = 0; bus_b.load_we = 0; bus_b.load_data = '0; bus_b.load_last = 0;
    bus_b.fetch_req  = 0; bus_b.pc = '0; bus_b.stall = 0; bus_b.flush = 0;
  endtask

  // Applies the rules for one rising edge using the inputs present at that edge.
  task automatic model_edge();
    logic [DW-1:0] e_i;
    longint        pcv;
    longint        widx;
    bit            run_now;
    e_i     = exp_q.pop_front();
    pcv     = longint'(bus.pc);
    widx    = pcv / 4;
    run_now = !m_load && !bus.load_start;
    if (bus.flush) begin
      e_i = '0; e_valid = 0; e_fault = 0; e_known = 1;
    end else if (bus.stall) begin
      e_i = e_i;
    end else if (bus.fetch_req && run_now) begin
      e_valid = 1;
      if ((pcv % 4) != 0 || widx >= DEPTH) begin
        e_i = '0; e_fault = 1; e_known = 1;
      end else begin
        e_i = m_mem[int'(widx)]; e_fault = 0; e_known = m_known[int'(widx)];
      end
    end else begin
      e_i = '0; e_valid = 0; e_fault = 0; e_known = 1;
    end
    exp_q.push_back(e_i);

    if (bus.load_start) begin
      m_load = 1; m_ptr = 0; m_cnt = 0; m_ovf = 0;
    end else if (m_load && bus.load_we) begin
      m_mem[m_ptr]   = bus.load_data;
      m_known[m_ptr] = 1;
      m_ptr = (m_ptr + 1) % DEPTH;
      if (m_ptr == 0) m_ovf = 1;
      if (m_cnt < DEPTH) m_cnt++;
      if (bus.load_last) m_load = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("busy",          bus.busy,          m_load);
    check("load_count",    bus.load_count,    m_cnt);
    check("load_overflow", bus.load_overflow, m_ovf);
    check("instr_valid",   bus.instr_valid,   e_valid);
    check("fault",         bus.fault,         e_fault);
    if (e_known) check("instruction", bus.instruction, exp_q[0]);
`ifdef INSTR_MEM_PARITY_EN
    check("parity_err",    bus.parity_err,    0);
`endif
  endtask

  task automatic apply_reset();
    rst = 1;
    #1;
    m_load = 0; m_ptr = 0; m_cnt = 0; m_ovf = 0;
    e_valid = 0; e_fault = 0; e_known = 1;
    exp_q = {};
    exp_q.push_back('0);
    check("rst_busy",        bus.busy,          0);
    check("rst_load_count",  bus.load_count,    0);
    check("rst_overflow",    bus.load_overflow, 0);
    check("rst_valid",       bus.instr_valid,   0);
    check("rst_fault",       bus.fault,         0);
    check("rst_instruction", bus.instruction,   0);
    @(negedge clk);
    rst = 0;
  endtask

  // stimulus
  initial begin
    prog[0] = 32'hE3A00014;
    prog[1] = 32'hE3A01A01;
    prog[2] = 32'hE0923002;
    rst = 1;
    set_idle();
    set_idle_b();
    apply_reset();

    // program load of three words
    bus.load_start = 1;
    tick();
    check("busy_after_start", bus.busy, 1);
    bus.load_start = 0;
    bus.load_we    = 1;
    for (int i = 0; i < 3; i++) begin
      bus.load_data = prog[i];
      bus.load_last = (i == 2);
      tick();
    end
    check("busy_after_last", bus.busy, 0);
    check("count_3", bus.load_count, 3);
    check("ovf_0", bus.load_overflow, 0);
    set_idle();

    // fetch hits and faults
    bus.fetch_req = 1; bus.pc = 4;
    tick();
    check("pc4_instr", bus.instruction, 32'hE3A01A01);
    check("pc4_valid", bus.instr_valid, 1);
    bus.pc = 6;
    tick();
    check("pc6_instr", bus.instruction, 0);
    check("pc6_fault", bus.fault, 1);
    bus.pc = 4 * DEPTH;
    tick();
    check("pc_oor_fault", bus.fault, 1);
    check("pc_oor_instr", bus.instruction, 0);

    // stall holds, flush beats stall
    bus.pc = 0;
    tick();
    bus.stall = 1; bus.pc = 8;
    repeat (3) tick();
    check("stall_instr", bus.instruction, 32'hE3A00014);
    check("stall_valid", bus.instr_valid, 1);
    bus.flush = 1;
    tick();
    check("flush_valid", bus.instr_valid, 0);
    set_idle();

    // randomized fetch traffic
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 9);
      bus.fetch_req = ($urandom_range(0, 3) != 0);
      if (r < 7)       bus.pc = AW'(4 * $urandom_range(0, 3));
      else if (r == 7) bus.pc = AW'($urandom);
      else if (r == 8) bus.pc = AW'(4 * $urandom_range(0, 5) + $urandom_range(1, 3));
      else             bus.pc = AW'(4 * DEPTH + 4 * $urandom_range(0, 3));
      bus.stall = ($urandom_range(0, 7) == 0);
      bus.flush = ($urandom_range(0, 11) == 0);
      tick();
    end
    set_idle();
    tick();

    // overflowing load with fetch attempts during LOAD
    bus.load_start = 1;
    tick();
    bus.load_start = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      bus.load_we   = 1;
      bus.load_data = $urandom;
      bus.load_last = (i == DEPTH);
      bus.fetch_req = ($urandom_range(0, 1) == 1);
      bus.pc        = AW'(4 * $urandom_range(0, 3));
      last_w        = bus.load_data;
      tick();
    end
    set_idle();
    check("ovf_set", bus.load_overflow, 1);
    check("count_sat", bus.load_count, DEPTH);
    bus.fetch_req = 1; bus.pc = 0;
    tick();
    check("wrap_word0", bus.instruction, last_w);
    bus.pc = 4;
    tick();
    set_idle();
    tick();

    // reset in the middle of a load keeps the written words
    wa = $urandom;
    wb = $urandom;
    bus.load_start = 1;
    tick();
    bus.load_start = 0; bus.load_we = 1; bus.load_data = wa;
    tick();
    bus.load_data = wb;
    tick();
    set_idle();
    apply_reset();
    bus.fetch_req = 1; bus.pc = 0;
    tick();
    check("midrst_w0", bus.instruction, wa);
    bus.pc = 4;
    tick();
    check("midrst_w1", bus.instruction, wb);
    set_idle();
    tick();

    // non-zero BASE_ADDR instance
    bus_b.load_start = 1;
    @(posedge clk); #1;
    bus_b.load_start = 0; bus_b.load_we = 1; bus_b.load_data = 32'h1111_2222; bus_b.load_last = 1;
    @(posedge clk); #1;
    check("b_busy_done", bus_b.busy, 0);
    set_idle_b();
    bus_b.fetch_req = 1; bus_b.pc = 32'hFC;
    @(posedge clk); #1;
    check("b_below_base_fault", bus_b.fault, 1);
    check("b_below_base_instr", bus_b.instruction, 0);
    bus_b.pc = 32'h100;
    @(posedge clk); #1;
    check("b_base_instr", bus_b.instruction, 32'h1111_2222);
    check("b_base_fault", bus_b.fault, 0);
    bus_b.pc = 32'h110;
    @(posedge clk); #1;
    check("b_oor_fault", bus_b.fault, 1);
    set_idle_b();

`ifdef INSTR_MEM_PARITY_EN
    dut.mem[1][DW] = ~dut.mem[1][DW];
    bus.fetch_req = 1; bus.pc = 4;
    @(posedge clk); #1;
    check("par_err", bus.parity_err, 1);
    check("par_fault", bus.fault, 1);
    check("par_instr", bus.instruction, 0);
    set_idle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // overall time bound
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
